// File: rtl/cache_ctrl_if.sv
// Signal bundle between cache_ctrl and its CPU port, tag table, data table and main memory.
// The master modport is the controller's view; slave is the surrounding environment.
interface cache_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;

  logic [2:0]  tc_line_read;
  logic [23:0] tc_tag_read;
  logic        tc_hit;
  logic        tc_channel;
  logic        tc_write;
  logic        tc_pos;
  logic [2:0]  tc_line_write;
  logic [23:0] tc_tag_write;

  logic        dt_we;
  logic        dt_way;
  logic [2:0]  dt_line;
  logic [2:0]  dt_word;
  logic [31:0] dt_wdata;
  logic [31:0] dt_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, tc_hit, tc_channel,
           dt_rdata, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, tc_line_read, tc_tag_read, tc_write, tc_pos,
           tc_line_write, tc_tag_write, dt_we, dt_way, dt_line, dt_word,
           dt_wdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, tc_hit, tc_channel,
           dt_rdata, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, tc_line_read, tc_tag_read, tc_write, tc_pos,
           tc_line_write, tc_tag_write, dt_we, dt_way, dt_line, dt_word,
           dt_wdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_ctrl.sv
// Sequencing controller for a 2-way, 8-set cache: hit/miss resolution, 8-word
// refill on load miss, write-through on store, per-set LRU victim selection.
module cache_ctrl (
  input  logic         clk,
  input  logic         rst,
  cache_ctrl_if.master bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] REFILL = 3'd1;
  localparam logic [2:0] TAGWR  = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] RESP   = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [7:0]  lru_q, lru_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        victim_q, victim_d;
  logic [31:0] rdata_q, rdata_d;

  logic [2:0]  set;
  logic [2:0]  word;
  logic        unused_addr_bits;

  assign set              = bus.cpu_addr[7:5];
  assign word             = bus.cpu_addr[4:2];
  assign unused_addr_bits = ^bus.cpu_addr[1:0];

  assign bus.tc_line_read  = set;
  assign bus.tc_tag_read   = bus.cpu_addr[31:8];
  assign bus.tc_line_write = set;
  assign bus.tc_tag_write  = bus.cpu_addr[31:8];
  assign bus.tc_pos        = victim_q;
  assign bus.dt_line       = set;
  assign bus.mem_wdata     = bus.cpu_wdata;
  assign bus.cpu_rdata     = rdata_q;

  always_comb begin
    state_d       = state_q;
    lru_d         = lru_q;
    cnt_d         = cnt_q;
    victim_d      = victim_q;
    rdata_d       = rdata_q;
    bus.cpu_ready = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {bus.cpu_addr[31:2], 2'b00};
    bus.tc_write  = 1'b0;
    bus.dt_we     = 1'b0;
    bus.dt_way    = bus.tc_channel;
    bus.dt_word   = word;
    bus.dt_wdata  = bus.cpu_wdata;

    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          if (bus.cpu_we) begin
            state_d = WRITE;
            if (bus.tc_hit) begin
              bus.dt_we  = 1'b1;
              lru_d[set] = ~bus.tc_channel;
            end
          end else if (bus.tc_hit) begin
            rdata_d    = bus.dt_rdata;
            lru_d[set] = ~bus.tc_channel;
            state_d    = RESP;
          end else begin
            victim_d = lru_q[set];
            cnt_d    = '0;
            state_d  = REFILL;
          end
        end
      end
      REFILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {bus.cpu_addr[31:5], cnt_q, 2'b00};
        bus.dt_way   = victim_q;
        bus.dt_word  = cnt_q;
        bus.dt_wdata = bus.mem_rdata;
        if (bus.mem_ack) begin
          bus.dt_we = 1'b1;
          if (cnt_q == word) rdata_d = bus.mem_rdata;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = TAGWR;
        end
      end
      TAGWR: begin
        bus.tc_write = 1'b1;
        lru_d[set]   = ~victim_q;
        state_d      = RESP;
      end
      WRITE: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        if (bus.mem_ack) state_d = RESP;
      end
      RESP: begin
        bus.cpu_ready = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are forced low for the whole reset cycle, so an abandoned
    // refill or store never leaks a request or table write past reset.
    if (!rst) begin
      bus.cpu_ready = 1'b0;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.tc_write  = 1'b0;
      bus.dt_we     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      lru_q    <= '0;
      cnt_q    <= '0;
      victim_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      lru_q    <= lru_d;
      cnt_q    <= cnt_d;
      victim_q <= victim_d;
      rdata_q  <= rdata_d;
    end
  end
endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Sequencing controller for the 2-way, 8-set instruction/data cache. It sits between the CPU memory port and main memory, and drives the cache tag table and data table. It resolves hits and misses, refills 8-word blocks on read misses, writes through on stores, and keeps a per-set LRU bit to choose the victim way. While a miss or store is outstanding the CPU is stalled through `cpu_ready`.

## Interface
- Parameters: none. Geometry is fixed at 8 sets, 2 ways, a 24-bit tag and 8 words × 32 bits per block. The address splits as tag = addr[31:8], set = addr[7:5], word = addr[4:2], and addr[1:0] is ignored.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous reset, active-low; sampled on the rising edge of `clk`.
- `cpu_req`  in  1  access request; held with `cpu_we`, `cpu_addr` and `cpu_wdata` stable until `cpu_ready`.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_addr`  in  32  byte address.
- `cpu_wdata`  in  32  store data.
- `cpu_rdata`  out  32  load data, registered; valid when `cpu_ready`=1.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `tc_line_read`  out  3  tag-table lookup set; always `cpu_addr[7:5]`.
- `tc_tag_read`  out  24  tag-table lookup tag; always `cpu_addr[31:8]`.
- `tc_hit`, `tc_channel`  in  1 each  combinational lookup result; `tc_channel`=1 means the hit is in way 1.
- `tc_write`  out  1  tag-table write strobe.
- `tc_pos`  out  1  way to write.
- `tc_line_write`  out  3  set to write.
- `tc_tag_write`  out  24  tag to write.
- `dt_we`  out  1  data-table word write strobe.
- `dt_way`  out  1  data-table way.
- `dt_line`  out  3  data-table set.
- `dt_word`  out  3  data-table word index.
- `dt_wdata`  out  32  data-table write data.
- `dt_rdata`  in  32  combinational read of (`dt_way`, `dt_line`, `dt_word`).
- `mem_req`  out  1  memory request; held until `mem_ack`.
- `mem_we`  out  1  1 = memory write.
- `mem_addr`  out  32  word-aligned memory address.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data; valid when `mem_ack`=1.
- `mem_ack`  in  1  one-cycle acknowledge.

## Operation
- States are IDLE, REFILL, TAGWR, WRITE and RESP.
- Reset (`rst`=0):
  - The state goes to IDLE.
  - `lru[7:0]` is cleared to 0.
  - The refill counter `cnt` is cleared to 0.
  - `cpu_rdata` is cleared to 0.
  - Every strobe output (`cpu_ready`, `mem_req`, `mem_we`, `tc_write`, `dt_we`) is driven to 0.
  - Reset is honoured in every state. An in-flight refill or store is abandoned, `mem_req` drops on the following cycle, and no tag write occurs.
- IDLE:
  - With `cpu_req`=1, `cpu_we`=0 and `tc_hit`=1 (load hit): latch `dt_rdata` from way = `tc_channel` into `cpu_rdata`, set `lru[set]` = !`tc_channel`, and go to RESP.
  - Load miss: record `victim` = `lru[set]`, clear `cnt` to 0, and go to REFILL.
  - Store (`cpu_we`=1): go to WRITE. If `tc_hit`=1, in this same cycle assert `dt_we` with way = `tc_channel`, word = addr[4:2] and data = `cpu_wdata`, and set `lru[set]` = !`tc_channel`. A store that misses does not allocate.
- REFILL:
  - `mem_req`=1, `mem_we`=0, `mem_addr` = {addr[31:5], `cnt`, 2'b00}.
  - On `mem_ack`: assert `dt_we` with way = `victim`, word = `cnt` and data = `mem_rdata`. If `cnt` == addr[4:2], also latch `mem_rdata` into `cpu_rdata`. Then increment `cnt`.
  - The ack with `cnt`=7 moves the state to TAGWR.
  - The tag table is not written during REFILL.
- TAGWR: assert `tc_write` for one cycle with pos = `victim`, line = set and tag = addr[31:8]. Set `lru[set]` = !`victim` and go to RESP.
- WRITE:
  - `mem_req`=1, `mem_we`=1, `mem_addr` = {addr[31:2], 2'b00}, `mem_wdata` = `cpu_wdata`.
  - On `mem_ack`, go to RESP.
- RESP: `cpu_ready`=1 for exactly one cycle, then go to IDLE. `cpu_req` is ignored in this cycle.

## Timing
- Load hit: `cpu_req` is sampled in IDLE in cycle 0, and `cpu_ready` is asserted in cycle 1.
- Load miss: `cpu_ready` is asserted 2 cycles after the 8th `mem_ack` (that ack's edge enters TAGWR, the next edge enters RESP). With single-cycle memory acks the total is 10 cycles after the request.
- Store: `cpu_ready` is asserted 1 cycle after `mem_ack`.
- `mem_addr` and `mem_we` are stable for as long as `mem_req`=1.
- `mem_addr` advances on the cycle after each ack. `mem_req` stays high between consecutive refill words.
- `mem_ack` seen outside REFILL and WRITE is ignored.
- `cnt` is 3 bits. Reaching 7 is the terminal condition; wrap-around to 0 is not used.
- Back-to-back requests: a request presented in the RESP cycle is accepted in the following IDLE cycle. The minimum spacing is therefore 2 cycles per hit.

## Test plan
- Cold miss:
  - Stimulus: reset, then load from 0x0000_0124 (set 1, word 1, tag 0x000001); memory returns data = word index × 0x11 with immediate acks.
  - Required response: 8 reads at 0x120 through 0x13C, `tc_write` with pos 0, line 1, tag 0x000001, and `cpu_ready` carrying `cpu_rdata`=0x11.
- Hit after fill: load 0x0000_0130 → `cpu_ready` one cycle after the request, `cpu_rdata`=0x44, `mem_req` stays 0.
- LRU replacement:
  - Stimulus: load misses to tag 0x000002 and then tag 0x000003, both in set 1.
  - Required response: tag 0x000002 fills way 1 (`tc_pos`=1) and tag 0x000003 replaces way 0 (`tc_pos`=0).
- Store hit:
  - Stimulus: store 0xDEADBEEF to 0x0000_0124 while that line is resident.
  - Required response: `dt_we` in the request cycle; a memory write to 0x124 is held until ack; `cpu_ready` follows 1 cycle later; a subsequent load returns 0xDEADBEEF.
- Store miss: store to 0x0000_0F00 → memory write only, no `dt_we` and no `tc_write`.
- Reset mid-refill:
  - Stimulus: drive `rst`=0 after the 3rd ack of a refill.
  - Required response: `mem_req` is 0 on the next cycle, there is no `tc_write`, the state is IDLE and `cpu_ready` stays 0.
